// File: rtl/game_pkg.sv
// Shared game datapath definitions: direction encoding, trajectory FSM states
// and screen geometry.
package game_pkg;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_DEC  = 2'b10;
  localparam logic [1:0] DIR_INC  = 2'b11;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RISE = 3'd2,
    ST_FALL = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/tick_divider.sv
// Divides the shared move tick by DIV. grav_step is high during the move tick
// that completes each group of DIV ticks, so callers can act on that same edge.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic grav_step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] gcnt;
  logic          last;

  assign last      = (gcnt == CW'(DIV - 1));
  assign grav_step = tick && last;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      gcnt <= '0;
    end else if (tick) begin
      gcnt <= last ? '0 : gcnt + CW'(1);
    end
  end

endmodule

// File: rtl/fruit_trajectory_ctrl.sv
// Per-fruit trajectory sequencer: launches one position updater, shapes its
// vertical speed for gravity on move ticks, and retires it off-screen or on kill.
module fruit_trajectory_ctrl #(
  parameter int SCREEN_H = 480,
  parameter int LAUNCH_Y = 479,
  parameter int GRAV_DIV = 4,
  parameter int VY_MAX   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       moveclk,
  input  logic       launch,
  input  logic [9:0] launch_x,
  input  logic [9:0] launch_vx,
  input  logic [9:0] launch_vy,
  input  logic       launch_left,
  input  logic       kill,
  input  logic [9:0] posy,
  output logic       obj_rst,
  output logic       obj_en,
  output logic [9:0] init_x,
  output logic [9:0] init_y,
  output logic [9:0] vx,
  output logic [9:0] vy,
  output logic [1:0] dx,
  output logic [1:0] dy,
  output logic       active,
  output logic       done,
  output logic       sliced
);

  import game_pkg::*;

  state_e     state, state_nx;
  logic [9:0] x_nx, vx_nx, vy_nx;
  logic       left, left_nx;
  logic       sliced_nx;
  logic       grav_step;
  logic       flying, fly_nx;

  assign flying = (state == ST_RISE) || (state == ST_FALL);
  assign fly_nx = (state_nx == ST_RISE) || (state_nx == ST_FALL);

  // Gravity cadence restarts with every flight and keeps running across RISE->FALL.
  tick_divider #(.DIV(GRAV_DIV)) u_tick_divider (
    .clk       (clk),
    .rst       (rst),
    .clr       (!flying),
    .tick      (moveclk),
    .grav_step (grav_step)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nx  = state;
    x_nx      = init_x;
    vx_nx     = vx;
    vy_nx     = vy;
    left_nx   = left;
    sliced_nx = sliced;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          x_nx      = launch_x;
          vx_nx     = launch_vx;
          vy_nx     = launch_vy;
          left_nx   = launch_left;
          sliced_nx = 1'b0;
          state_nx  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_nx = (vy == 10'd0) ? ST_FALL : ST_RISE;
      end
      ST_RISE: begin
        if (kill) begin
          sliced_nx = 1'b1;
          state_nx  = ST_DONE;
        end else if (moveclk && (posy < vy)) begin
          // Next move would carry y through 0; start falling from rest instead.
          vy_nx    = 10'd0;
          state_nx = ST_FALL;
        end else if (grav_step) begin
          if (vy == 10'd1) begin
            vy_nx    = 10'd0;
            state_nx = ST_FALL;
          end else begin
            vy_nx = vy - 10'd1;
          end
        end
      end
      ST_FALL: begin
        if (kill) begin
          sliced_nx = 1'b1;
          state_nx  = ST_DONE;
        end else if (posy >= 10'(SCREEN_H)) begin
          sliced_nx = 1'b0;
          state_nx  = ST_DONE;
        end else if (grav_step && (vy < 10'(VY_MAX))) begin
          vy_nx = vy + 10'd1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      init_x  <= '0;
      init_y  <= 10'(LAUNCH_Y);
      vx      <= '0;
      vy      <= '0;
      left    <= 1'b0;
      dx      <= DIR_HOLD;
      dy      <= DIR_HOLD;
      obj_rst <= 1'b1;
      obj_en  <= 1'b0;
      active  <= 1'b0;
      done    <= 1'b0;
      sliced  <= 1'b0;
    end else begin
      state   <= state_nx;
      init_x  <= x_nx;
      init_y  <= 10'(LAUNCH_Y);
      vx      <= vx_nx;
      vy      <= vy_nx;
      left    <= left_nx;
      sliced  <= sliced_nx;
      obj_rst <= (state_nx == ST_IDLE) || (state_nx == ST_LOAD);
      obj_en  <= fly_nx;
      active  <= fly_nx;
      done    <= (state_nx == ST_DONE);
      if (!fly_nx || vx_nx == 10'd0) begin
        dx <= DIR_HOLD;
      end else begin
        dx <= left_nx ? DIR_DEC : DIR_INC;
      end
      case (state_nx)
        ST_RISE: dy <= DIR_DEC;
        ST_FALL: dy <= DIR_INC;
        default: dy <= DIR_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_fruit_trajectory_ctrl.sv
// Directed bench for fruit_trajectory_ctrl: one instance with GRAV_DIV=1 for the
// flight/kill/clip/launch-ignore cases, one with GRAV_DIV=4 for the divided cadence.
module tb_fruit_trajectory_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       moveclk = 1'b0;
  logic       launch = 1'b0, launch4 = 1'b0;
  logic [9:0] launch_x = '0, launch_vx = '0, launch_vy = '0;
  logic       launch_left = 1'b0;
  logic       kill = 1'b0, kill4 = 1'b0;
  logic [9:0] posy = 10'd479, posy4 = 10'd100;

  logic       obj_rst, obj_en, active, done, sliced;
  logic [9:0] init_x, init_y, vx, vy;
  logic [1:0] dx, dy;
  logic       obj_rst4, obj_en4, active4, done4, sliced4;
  logic [9:0] init_x4, init_y4, vx4, vy4;
  logic [1:0] dx4, dy4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fruit_trajectory_ctrl #(.GRAV_DIV(1)) dut (
    .clk(clk), .rst(rst), .moveclk(moveclk), .launch(launch),
    .launch_x(launch_x), .launch_vx(launch_vx), .launch_vy(launch_vy),
    .launch_left(launch_left), .kill(kill), .posy(posy),
    .obj_rst(obj_rst), .obj_en(obj_en), .init_x(init_x), .init_y(init_y),
    .vx(vx), .vy(vy), .dx(dx), .dy(dy), .active(active), .done(done), .sliced(sliced)
  );

  fruit_trajectory_ctrl #(.GRAV_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .moveclk(moveclk), .launch(launch4),
    .launch_x(launch_x), .launch_vx(launch_vx), .launch_vy(launch_vy),
    .launch_left(launch_left), .kill(kill4), .posy(posy4),
    .obj_rst(obj_rst4), .obj_en(obj_en4), .init_x(init_x4), .init_y(init_y4),
    .vx(vx4), .vy(vy4), .dx(dx4), .dy(dy4), .active(active4), .done(done4), .sliced(sliced4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic move_tick();
    moveclk = 1'b1;
    step();
    moveclk = 1'b0;
  endtask

  task automatic do_launch(input logic [9:0] x, input logic [9:0] svx,
                           input logic [9:0] svy, input logic lft);
    launch_x = x; launch_vx = svx; launch_vy = svy; launch_left = lft;
    launch = 1'b1;
    step();
    launch = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;

    // Reset values
    check("rst_obj_rst", obj_rst, 1);
    check("rst_obj_en", obj_en, 0);
    check("rst_init_x", init_x, 0);
    check("rst_init_y", init_y, 479);
    check("rst_vx", vx, 0);
    check("rst_vy", vy, 0);
    check("rst_dx", dx, 0);
    check("rst_dy", dy, 0);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_sliced", sliced, 0);

    // Full flight: x=100 vx=2 right vy=3, GRAV_DIV=1
    posy = 10'd479;
    do_launch(10'd100, 10'd2, 10'd3, 1'b0);
    check("load_obj_rst", obj_rst, 1);
    check("load_obj_en", obj_en, 0);
    check("load_init_x", init_x, 100);
    check("load_vx", vx, 2);
    step();
    check("rise_obj_rst", obj_rst, 0);
    check("rise_obj_en", obj_en, 1);
    check("rise_active", active, 1);
    check("rise_dy", dy, 2'b10);
    check("rise_dx", dx, 2'b11);
    check("rise_vy", vy, 3);
    for (int i = 2; i >= 0; i--) begin
      move_tick();
      check("rise_vy_step", vy, 32'(i));
    end
    check("fall_dy", dy, 2'b11);
    check("fall_active", active, 1);
    for (int i = 1; i <= 14; i++) begin
      move_tick();
      check("fall_vy_ramp", vy, (i < 12) ? 32'(i) : 32'd12);
    end
    step();
    check("fall_vy_no_tick", vy, 12);

    // Off-screen exit with a model updater advancing posy by vy per tick
    posy = 10'd470;
    move_tick();
    check("fall_no_exit_470", done, 0);
    posy = posy + vy;
    check("model_posy", posy, 482);
    step();
    check("exit_done", done, 1);
    check("exit_sliced", sliced, 0);
    check("exit_obj_en", obj_en, 0);
    check("exit_active", active, 0);
    step();
    check("idle_done", done, 0);
    check("idle_obj_rst", obj_rst, 1);
    check("idle_obj_en", obj_en, 0);

    // Kill in RISE coinciding with a gravity tick
    posy = 10'd400;
    do_launch(10'd50, 10'd3, 10'd5, 1'b1);
    step();
    check("kill_rise_dx_left", dx, 2'b10);
    move_tick();
    check("kill_pre_vy", vy, 4);
    kill = 1'b1;
    moveclk = 1'b1;
    step();
    kill = 1'b0;
    moveclk = 1'b0;
    check("kill_done", done, 1);
    check("kill_sliced", sliced, 1);
    check("kill_vy_held", vy, 4);
    step();
    check("kill_done_one_cycle", done, 0);
    check("kill_idle_obj_rst", obj_rst, 1);

    // Top clip: vy=20 with posy=15 on a tick
    posy = 10'd479;
    do_launch(10'd200, 10'd1, 10'd20, 1'b0);
    step();
    check("clip_rise_vy", vy, 20);
    posy = 10'd15;
    move_tick();
    check("clip_dy", dy, 2'b11);
    check("clip_vy", vy, 0);
    check("clip_active", active, 1);

    // Launch during FALL is ignored
    do_launch(10'd300, 10'd7, 10'd9, 1'b1);
    check("ign_init_x", init_x, 200);
    check("ign_vx", vx, 1);
    check("ign_vy", vy, 0);
    check("ign_active", active, 1);
    check("ign_obj_rst", obj_rst, 0);
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("fall_kill_sliced", sliced, 1);
    check("fall_kill_done", done, 1);
    step();

    // Launch together with reset
    launch_x = 10'd77; launch_vx = 10'd5; launch_vy = 10'd6;
    launch = 1'b1;
    rst = 1'b1;
    step();
    launch = 1'b0;
    rst = 1'b0;
    check("rl_obj_rst", obj_rst, 1);
    check("rl_obj_en", obj_en, 0);
    check("rl_init_x", init_x, 0);
    check("rl_vx", vx, 0);
    check("rl_vy", vy, 0);
    check("rl_done", done, 0);
    step();
    check("rl_still_idle", obj_en, 0);

    // GRAV_DIV=4, vy=0 vx=0: LOAD straight to FALL, vy steps every 4th tick
    launch_x = 10'd10; launch_vx = 10'd0; launch_vy = 10'd0; launch_left = 1'b0;
    launch4 = 1'b1;
    step();
    launch4 = 1'b0;
    check("d4_load_obj_rst", obj_rst4, 1);
    step();
    check("d4_fall_dy", dy4, 2'b11);
    check("d4_fall_dx", dx4, 2'b00);
    check("d4_fall_obj_en", obj_en4, 1);
    check("d4_fall_vy0", vy4, 0);
    for (int i = 1; i <= 8; i++) begin
      move_tick();
      check("d4_vy_cadence", vy4, 32'(i / 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
